// File: rtl/issue_hazard_ctrl_if.sv
// Decode-stage issue/stall control bundle between the IF/ID pipeline register,
// the EX branch resolver, data memory ready and the hazard controller.
interface issue_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ins;
    logic             ins_valid;
    logic             cond_valid;
    logic             cond_taken;
    logic             mem_busy;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_bubble;
    logic             flush;
    logic             pc_sel;
    logic             pipe_freeze;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output ins, ins_valid, cond_valid, cond_taken, mem_busy,
        input  pc_stall, ifid_stall, idex_bubble, flush, pc_sel, pipe_freeze,
               ctrl_state, stall_cycles
    );

    modport slave (
        input  ins, ins_valid, cond_valid, cond_taken, mem_busy,
        output pc_stall, ifid_stall, idex_bubble, flush, pc_sel, pipe_freeze,
               ctrl_state, stall_cycles
    );
endinterface

// File: rtl/issue_hazard_ctrl.sv
// Decode-stage issue controller: load-use stalls, jump/conditional-jump
// redirect and flush sequencing, memory-busy freeze, saturating stall counter.
module issue_hazard_ctrl #(
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    issue_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LD_STALL = 2'b01,
        BR_WAIT  = 2'b10,
        FLUSH    = 2'b11
    } state_t;

    localparam logic [2:0]       LOAD_LAT_C = 3'(LOAD_LAT);
    localparam logic [1:0]       BR_PEN_C   = 2'(BR_PENALTY);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [4:0]       ld_dest_q, ld_dest_d;
    logic [2:0]       ld_cnt_q, ld_cnt_d;
    logic [1:0]       fl_cnt_q, fl_cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic       pc_stall_s, ifid_stall_s, idex_bubble_s, flush_s, pc_sel_s, pipe_freeze_s;
    logic [5:0] opcode;
    logic [4:0] fld_d, fld_a, fld_b;
    logic       is_ld, is_st, is_jmp, is_cj, is_imm;
    logic       use_a, use_b, use_d, hazard;
    logic       unused_ins_bits;

    assign opcode = bus.ins[31:26];
    assign fld_d  = bus.ins[25:21];
    assign fld_a  = bus.ins[20:16];
    assign fld_b  = bus.ins[15:11];
    assign unused_ins_bits = ^bus.ins[10:0];

    assign is_ld  = (opcode == 6'b010100);
    assign is_st  = (opcode == 6'b010101);
    assign is_jmp = (opcode == 6'b011000);
    assign is_cj  = (opcode[5:2] == 4'b0111);
    assign is_imm = (opcode[5:3] == 3'b001);

    assign use_a  = ~(is_jmp | is_cj);
    assign use_b  = ~(is_imm | is_ld | is_st | is_jmp | is_cj);
    assign use_d  = is_st;
    assign hazard = (ld_cnt_q != 3'd0) &&
                    ((use_a && (fld_a == ld_dest_q)) ||
                     (use_b && (fld_b == ld_dest_q)) ||
                     (use_d && (fld_d == ld_dest_q)));

    // Next-state and combinational control decode.
    always_comb begin
        state_d       = state_q;
        ld_dest_d     = ld_dest_q;
        ld_cnt_d      = ld_cnt_q;
        fl_cnt_d      = fl_cnt_q;
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        idex_bubble_s = 1'b0;
        flush_s       = 1'b0;
        pc_sel_s      = 1'b0;
        pipe_freeze_s = 1'b0;

        if (bus.mem_busy) begin
            pc_stall_s    = 1'b1;
            ifid_stall_s  = 1'b1;
            pipe_freeze_s = 1'b1;
        end else begin
            ld_cnt_d = (ld_cnt_q != 3'd0) ? (ld_cnt_q - 3'd1) : 3'd0;
            case (state_q)
                FLUSH: begin
                    flush_s       = 1'b1;
                    idex_bubble_s = 1'b1;
                    fl_cnt_d      = (fl_cnt_q != 2'd0) ? (fl_cnt_q - 2'd1) : 2'd0;
                    if (fl_cnt_q <= 2'd1) begin
                        state_d = RUN;
                    end else begin
                        state_d = FLUSH;
                    end
                end
                BR_WAIT: begin
                    // Not-taken keeps IF/ID held this cycle so the fall-through issues next cycle.
                    idex_bubble_s = 1'b1;
                    if (bus.cond_valid && bus.cond_taken) begin
                        pc_sel_s = 1'b1;
                        state_d  = FLUSH;
                        fl_cnt_d = BR_PEN_C;
                    end else if (bus.cond_valid) begin
                        pc_stall_s   = 1'b1;
                        ifid_stall_s = 1'b1;
                        state_d      = RUN;
                    end else begin
                        pc_stall_s   = 1'b1;
                        ifid_stall_s = 1'b1;
                        state_d      = BR_WAIT;
                    end
                end
                default: begin
                    if (!bus.ins_valid) begin
                        idex_bubble_s = 1'b1;
                        state_d       = RUN;
                    end else if (hazard) begin
                        pc_stall_s    = 1'b1;
                        ifid_stall_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                        state_d       = LD_STALL;
                    end else begin
                        state_d = RUN;
                        if (is_ld) begin
                            ld_dest_d = fld_d;
                            ld_cnt_d  = LOAD_LAT_C;
                        end else if (is_jmp) begin
                            pc_sel_s = 1'b1;
                            state_d  = FLUSH;
                            fl_cnt_d = BR_PEN_C;
                        end else if (is_cj) begin
                            state_d = BR_WAIT;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
            endcase
        end

        if (pc_stall_s && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // State, load window, flush counter and stall counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            ld_dest_q <= 5'd0;
            ld_cnt_q  <= 3'd0;
            fl_cnt_q  <= 2'd0;
            stall_q   <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            ld_dest_q <= ld_dest_d;
            ld_cnt_q  <= ld_cnt_d;
            fl_cnt_q  <= fl_cnt_d;
            stall_q   <= stall_d;
        end
    end

    // Reset gates the combinational controls so the pipe is quiet while held in reset.
    assign bus.pc_stall     = reset & pc_stall_s;
    assign bus.ifid_stall   = reset & ifid_stall_s;
    assign bus.idex_bubble  = reset & idex_bubble_s;
    assign bus.flush        = reset & flush_s;
    assign bus.pc_sel       = reset & pc_sel_s;
    assign bus.pipe_freeze  = reset & pipe_freeze_s;
    assign bus.ctrl_state   = state_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Bench for issue_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_issue_hazard_ctrl;
    localparam int LAT = 1;
    localparam int BRP = 1;
    localparam int CW  = 16;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_ST  = 6'b010101;
    localparam logic [5:0] OP_JMP = 6'b011000;
    localparam logic [5:0] OP_CJ  = 6'b011100;
    localparam logic [5:0] OP_IMM = 6'b001000;

    localparam int M_RUN = 0, M_LDS = 1, M_BRW = 2, M_FL = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;

    issue_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    issue_hazard_ctrl #(.LOAD_LAT(LAT), .BR_PENALTY(BRP), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: pipeline mode, load window, flush countdown, stall tally.
    int m_mode, m_ld_dest, m_ld_win, m_fl_left, m_stalls;
    logic e_pcs, e_ifs, e_bub, e_fl, e_sel, e_frz;

    function automatic logic [31:0] mk(input logic [5:0] op, input int d, input int a, input int b);
        mk = {op, 5'(d), 5'(a), 5'(b), 11'd0};
    endfunction

    task automatic model_reset();
        m_mode = M_RUN; m_ld_dest = 0; m_ld_win = 0; m_fl_left = 0; m_stalls = 0;
    endtask

    // Derives expected controls from the current model state and inputs; returns hazard.
    task automatic compute_expected(output bit haz);
        logic [5:0] op;
        int srcs[$];
        bit ld, st, jmp, cj, imm;
        op  = bus.ins[31:26];
        ld  = (op == OP_LD);
        st  = (op == OP_ST);
        jmp = (op == OP_JMP);
        cj  = (op[5:2] == 4'b0111);
        imm = (op[5:3] == 3'b001);
        if (!jmp && !cj) srcs.push_back(int'(bus.ins[20:16]));
        if (!(imm || ld || st || jmp || cj)) srcs.push_back(int'(bus.ins[15:11]));
        if (st) srcs.push_back(int'(bus.ins[25:21]));
        haz = 1'b0;
        if (m_ld_win > 0) foreach (srcs[i]) if (srcs[i] == m_ld_dest) haz = 1'b1;
        {e_pcs, e_ifs, e_bub, e_fl, e_sel, e_frz} = 6'b000000;
        if (!reset) begin
            haz = 1'b0;
        end else if (bus.mem_busy) begin
            e_pcs = 1'b1; e_ifs = 1'b1; e_frz = 1'b1;
        end else if (m_mode == M_FL) begin
            e_fl = 1'b1; e_bub = 1'b1;
        end else if (m_mode == M_BRW) begin
            e_bub = 1'b1;
            if (bus.cond_valid && bus.cond_taken) e_sel = 1'b1;
            else begin e_pcs = 1'b1; e_ifs = 1'b1; end
        end else if (!bus.ins_valid) begin
            e_bub = 1'b1;
        end else if (haz) begin
            e_pcs = 1'b1; e_ifs = 1'b1; e_bub = 1'b1;
        end else if (jmp) begin
            e_sel = 1'b1;
        end
    endtask

    task automatic model_advance();
        bit haz;
        logic [5:0] op;
        compute_expected(haz);
        op = bus.ins[31:26];
        if (!reset) begin
            model_reset();
        end else if (bus.mem_busy) begin
            if (m_stalls < 65535) m_stalls++;
        end else begin
            if (e_pcs && m_stalls < 65535) m_stalls++;
            if (m_ld_win > 0) m_ld_win--;
            case (m_mode)
                M_FL: begin
                    m_fl_left--;
                    if (m_fl_left <= 0) m_mode = M_RUN;
                end
                M_BRW: begin
                    if (bus.cond_valid && bus.cond_taken) begin m_mode = M_FL; m_fl_left = BRP; end
                    else if (bus.cond_valid) m_mode = M_RUN;
                end
                default: begin
                    if (!bus.ins_valid) m_mode = M_RUN;
                    else if (haz) m_mode = M_LDS;
                    else begin
                        m_mode = M_RUN;
                        if (op == OP_LD) begin m_ld_dest = int'(bus.ins[25:21]); m_ld_win = LAT; end
                        else if (op == OP_JMP) begin m_mode = M_FL; m_fl_left = BRP; end
                        else if (op[5:2] == 4'b0111) m_mode = M_BRW;
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic cv, input logic ct, input logic mb);
        bus.ins = ins; bus.ins_valid = v; bus.cond_valid = cv; bus.cond_taken = ct; bus.mem_busy = mb;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        drive(mk(OP_ADD, 0, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        drive(mk(OP_LD, 1, 2, 3), 1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if (bus.pc_stall !== 1'b0 || bus.pipe_freeze !== 1'b0) begin
            bad++; $display("FAIL reset_gate: pc_stall=%b pipe_freeze=%b want 0 0", bus.pc_stall, bus.pipe_freeze);
        end
        tick(); tick(); tick();
        reset = 1'b1;
        drive(mk(OP_ADD, 0, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.pc_stall, bus.ifid_stall, bus.idex_bubble, bus.flush, bus.pc_sel, bus.pipe_freeze} !== 6'b000000 ||
            bus.ctrl_state !== 2'b00 || bus.stall_cycles !== 16'd0) begin
            bad++; $display("FAIL reset_state: ctl=%b%b%b%b%b%b st=%b cnt=%0d want 000000 00 0", bus.pc_stall, bus.ifid_stall,
                bus.idex_bubble, bus.flush, bus.pc_sel, bus.pipe_freeze, bus.ctrl_state, bus.stall_cycles);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(mk(OP_LD, 5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(mk(OP_ADD, 7, 5, 1), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.pc_stall !== 1'b1 || bus.idex_bubble !== 1'b1) begin
            bad++; $display("FAIL ld_use_stall: pc_stall=%b bubble=%b want 1 1", bus.pc_stall, bus.idex_bubble);
        end
        tick();
        total++;
        if (bus.pc_stall !== 1'b0 || bus.idex_bubble !== 1'b0 || bus.ctrl_state !== 2'b01 || bus.stall_cycles !== 16'd1) begin
            bad++; $display("FAIL ld_use_issue: pc_stall=%b bubble=%b st=%b cnt=%0d want 0 0 01 1",
                bus.pc_stall, bus.idex_bubble, bus.ctrl_state, bus.stall_cycles);
        end
        tick();
        drive(mk(OP_LD, 5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(mk(OP_ADD, 7, 6, 1), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.pc_stall !== 1'b0) begin
            bad++; $display("FAIL ld_no_dep: pc_stall=%b want 0", bus.pc_stall);
        end
        tick();
        drive(mk(OP_LD, 0, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(mk(OP_IMM, 3, 4, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.pc_stall !== 1'b0) begin
            bad++; $display("FAIL imm_b_unused: pc_stall=%b want 0", bus.pc_stall);
        end
        drive(mk(OP_ADD, 3, 4, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.pc_stall !== 1'b1) begin
            bad++; $display("FAIL r0_b_dep: pc_stall=%b want 1", bus.pc_stall);
        end
        drive(mk(OP_ST, 0, 4, 9), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.pc_stall !== 1'b1) begin
            bad++; $display("FAIL st_data_dep: pc_stall=%b want 1", bus.pc_stall);
        end
        tick();
    endtask

    task automatic test_jmp();
        do_reset();
        drive(mk(OP_JMP, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.pc_sel !== 1'b1 || bus.flush !== 1'b0 || bus.pc_stall !== 1'b0) begin
            bad++; $display("FAIL jmp_issue: pc_sel=%b flush=%b pc_stall=%b want 1 0 0", bus.pc_sel, bus.flush, bus.pc_stall);
        end
        tick();
        drive(mk(OP_ADD, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.flush !== 1'b1 || bus.idex_bubble !== 1'b1 || bus.pc_sel !== 1'b0 || bus.ctrl_state !== 2'b11) begin
            bad++; $display("FAIL jmp_flush: flush=%b bubble=%b pc_sel=%b st=%b want 1 1 0 11",
                bus.flush, bus.idex_bubble, bus.pc_sel, bus.ctrl_state);
        end
        tick();
        total++;
        if (bus.flush !== 1'b0 || bus.ctrl_state !== 2'b00) begin
            bad++; $display("FAIL jmp_done: flush=%b st=%b want 0 00", bus.flush, bus.ctrl_state);
        end
    endtask

    task automatic test_cj();
        do_reset();
        drive(mk(OP_CJ, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(mk(OP_ADD, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.pc_stall !== 1'b1 || bus.ctrl_state !== 2'b10) begin
            bad++; $display("FAIL cj_wait: pc_stall=%b st=%b want 1 10", bus.pc_stall, bus.ctrl_state);
        end
        tick();
        drive(mk(OP_ADD, 1, 2, 3), 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (bus.pc_stall !== 1'b1 || bus.pc_sel !== 1'b0 || bus.flush !== 1'b0) begin
            bad++; $display("FAIL cj_not_taken: pc_stall=%b pc_sel=%b flush=%b want 1 0 0", bus.pc_stall, bus.pc_sel, bus.flush);
        end
        tick();
        drive(mk(OP_ADD, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.ctrl_state !== 2'b00 || bus.pc_stall !== 1'b0 || bus.flush !== 1'b0 || bus.stall_cycles !== 16'd2) begin
            bad++; $display("FAIL cj_nt_done: st=%b pc_stall=%b flush=%b cnt=%0d want 00 0 0 2",
                bus.ctrl_state, bus.pc_stall, bus.flush, bus.stall_cycles);
        end
        drive(mk(OP_CJ, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(mk(OP_ADD, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(mk(OP_ADD, 1, 2, 3), 1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if (bus.pc_sel !== 1'b1 || bus.pc_stall !== 1'b0) begin
            bad++; $display("FAIL cj_taken: pc_sel=%b pc_stall=%b want 1 0", bus.pc_sel, bus.pc_stall);
        end
        tick();
        drive(mk(OP_ADD, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.flush !== 1'b1 || bus.ctrl_state !== 2'b11 || bus.pc_sel !== 1'b0) begin
            bad++; $display("FAIL cj_flush: flush=%b st=%b pc_sel=%b want 1 11 0", bus.flush, bus.ctrl_state, bus.pc_sel);
        end
        tick();
        total++;
        if (bus.flush !== 1'b0 || bus.ctrl_state !== 2'b00) begin
            bad++; $display("FAIL cj_t_done: flush=%b st=%b want 0 00", bus.flush, bus.ctrl_state);
        end
    endtask

    task automatic test_mem_busy();
        do_reset();
        drive(mk(OP_LD, 5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(mk(OP_ADD, 7, 5, 1), 1'b1, 1'b1, 1'b1, 1'b1);
            total++;
            if (bus.pipe_freeze !== 1'b1 || bus.pc_stall !== 1'b1 || bus.idex_bubble !== 1'b0 || bus.pc_sel !== 1'b0) begin
                bad++; $display("FAIL busy_freeze[%0d]: frz=%b pc_stall=%b bubble=%b pc_sel=%b want 1 1 0 0",
                    i, bus.pipe_freeze, bus.pc_stall, bus.idex_bubble, bus.pc_sel);
            end
            tick();
        end
        drive(mk(OP_ADD, 7, 5, 1), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.pipe_freeze !== 1'b0 || bus.pc_stall !== 1'b1 || bus.idex_bubble !== 1'b1) begin
            bad++; $display("FAIL busy_resume: frz=%b pc_stall=%b bubble=%b want 0 1 1", bus.pipe_freeze, bus.pc_stall, bus.idex_bubble);
        end
        tick();
        total++;
        if (bus.pc_stall !== 1'b0 || bus.stall_cycles !== 16'd4) begin
            bad++; $display("FAIL busy_total: pc_stall=%b cnt=%0d want 0 4", bus.pc_stall, bus.stall_cycles);
        end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        drive(mk(OP_JMP, 0, 0, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(mk(OP_ADD, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (bus.flush !== 1'b1) begin
            bad++; $display("FAIL mid_flush_pre: flush=%b want 1", bus.flush);
        end
        reset = 1'b0;
        model_reset();
        #1;
        total++;
        if (bus.flush !== 1'b0 || bus.idex_bubble !== 1'b0 || bus.ctrl_state !== 2'b00) begin
            bad++; $display("FAIL mid_flush_rst: flush=%b bubble=%b st=%b want 0 0 00", bus.flush, bus.idex_bubble, bus.ctrl_state);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        total++;
        if (bus.ctrl_state !== 2'b00 || bus.flush !== 1'b0 || bus.pc_stall !== 1'b0) begin
            bad++; $display("FAIL mid_flush_run: st=%b flush=%b pc_stall=%b want 00 0 0", bus.ctrl_state, bus.flush, bus.pc_stall);
        end
    endtask

    task automatic test_random();
        bit haz;
        logic [5:0] op;
        logic [5:0] got, exp;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 5))
                0: op = OP_LD;
                1: op = OP_ST;
                2: op = ($urandom_range(0, 3) == 0) ? OP_JMP : OP_ADD;
                3: op = ($urandom_range(0, 2) == 0) ? {4'b0111, 2'($urandom_range(0, 3))} : OP_ADD;
                4: op = {3'b001, 3'($urandom_range(0, 7))};
                default: op = OP_ADD;
            endcase
            bus.ins = mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            bus.ins[10:0] = 11'($urandom);
            bus.ins_valid  = ($urandom_range(0, 4) != 0);
            bus.cond_valid = ($urandom_range(0, 2) == 0);
            bus.cond_taken = 1'($urandom);
            bus.mem_busy   = ($urandom_range(0, 9) == 0);
            #1;
            compute_expected(haz);
            got = {bus.pc_stall, bus.ifid_stall, bus.idex_bubble, bus.flush, bus.pc_sel, bus.pipe_freeze};
            exp = {e_pcs, e_ifs, e_bub, e_fl, e_sel, e_frz};
            total++;
            if (got !== exp) begin
                bad++; $display("FAIL rnd_ctl[%0d]: got=%b want=%b", n, got, exp);
            end
            total++;
            if (bus.ctrl_state !== 2'(m_mode)) begin
                bad++; $display("FAIL rnd_state[%0d]: got=%b want=%0d", n, bus.ctrl_state, m_mode);
            end
            total++;
            if (bus.stall_cycles !== 16'(m_stalls)) begin
                bad++; $display("FAIL rnd_cnt[%0d]: got=%0d want=%0d", n, bus.stall_cycles, m_stalls);
            end
            tick();
        end
    endtask

    initial begin
        bus.ins = 32'd0; bus.ins_valid = 1'b0; bus.cond_valid = 1'b0; bus.cond_taken = 1'b0; bus.mem_busy = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_load_use();
        test_jmp();
        test_cj();
        test_mem_busy();
        test_reset_mid_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
